// File: rtl/split_recorder.sv
// split_recorder: lap-time FIFO for the stopwatch.
// Captures {minutes, seconds} on a lap button edge and shows the oldest
// stored lap as BCD digits. The rd button pops to the next lap.
// Storage is a circular buffer of DEPTH entries. A sticky overflow flag
// records any lap that was dropped because the buffer was full.
module split_recorder #(
   parameter int DEPTH = 4
) (
   input  logic                         incClk,
   input  logic                         rst,
   input  logic [5:0]                   minutes,
   input  logic [5:0]                   seconds,
   input  logic                         adj,
   input  logic                         lap_btn,
   input  logic                         rd_btn,
   input  logic                         clr,
   output logic [2:0]                   lap_min_tens,
   output logic [3:0]                   lap_min_ones,
   output logic [2:0]                   lap_sec_tens,
   output logic [3:0]                   lap_sec_ones,
   output logic                         lap_valid,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
   output logic                         empty,
   output logic                         overflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic            lap_prev_q, rd_prev_q;
   // arm_q stays low for the first edge after reset so that a button
   // held across reset release is absorbed into history, not seen as a press
   logic            arm_q;
   logic [PW-1:0]   head_q, head_d;
   logic [PW-1:0]   tail_q, tail_d;
   logic [CW-1:0]   count_q, count_d;
   logic            ovf_q, ovf_d;
   logic [11:0]     mem_q [DEPTH];

   logic            lap_req, rd_req, do_wr, do_pop, drop, wr_en;
   logic            full_w, empty_w;
   logic [11:0]     wr_data;
   logic [11:0]     head_entry;
   logic [6:0]      min_bcd, sec_bcd;

   logic [2:0]      min_tens_q, sec_tens_q;
   logic [3:0]      min_ones_q, sec_ones_q;
   logic            valid_q;

   function automatic logic [5:0] sat59(input logic [5:0] v);
      return (v > 6'd59) ? 6'd59 : v;
   endfunction

   // Returns {tens[2:0], ones[3:0]} for 0..59.
   function automatic logic [6:0] to_bcd(input logic [5:0] v);
      logic [2:0] t;
      logic [3:0] o;
      if (v >= 6'd50) begin
         t = 3'd5; o = 4'(v - 6'd50);
      end else if (v >= 6'd40) begin
         t = 3'd4; o = 4'(v - 6'd40);
      end else if (v >= 6'd30) begin
         t = 3'd3; o = 4'(v - 6'd30);
      end else if (v >= 6'd20) begin
         t = 3'd2; o = 4'(v - 6'd20);
      end else if (v >= 6'd10) begin
         t = 3'd1; o = 4'(v - 6'd10);
      end else begin
         t = 3'd0; o = v[3:0];
      end
      return {t, o};
   endfunction

   assign full_w  = (count_q == CW'(DEPTH));
   assign empty_w = (count_q == '0);
   assign wr_data = {sat59(minutes), sat59(seconds)};

   // Request detection and next-state for pointers, count and overflow.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      wr_en   = 1'b0;

      lap_req = arm_q & lap_btn & ~lap_prev_q;
      rd_req  = arm_q & rd_btn & ~rd_prev_q;
      do_pop  = rd_req & ~empty_w;
      // a pop in the same cycle frees the slot a full buffer would need
      do_wr   = lap_req & ~adj & (~full_w | do_pop);
      drop    = lap_req & ~adj & full_w & ~rd_req;

      if (clr) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
         ovf_d   = 1'b0;
      end else begin
         wr_en = do_wr;
         if (do_wr)  tail_d = tail_q + PW'(1);
         if (do_pop) head_d = head_q + PW'(1);
         if (do_wr && !do_pop)      count_d = count_q + CW'(1);
         else if (!do_wr && do_pop) count_d = count_q - CW'(1);
         if (drop) ovf_d = 1'b1;
      end
   end

   // Control state: button history, arming, pointers, count, overflow.
   always_ff @(posedge incClk or posedge rst) begin
      if (rst) begin
         lap_prev_q <= 1'b0;
         rd_prev_q  <= 1'b0;
         arm_q      <= 1'b0;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         ovf_q      <= 1'b0;
      end else begin
         lap_prev_q <= lap_btn;
         rd_prev_q  <= rd_btn;
         arm_q      <= 1'b1;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         ovf_q      <= ovf_d;
      end
   end

   // Lap storage; contents are don't-care until written.
   always_ff @(posedge incClk) begin
      if (wr_en) mem_q[tail_q] <= wr_data;
   end

   assign head_entry = mem_q[head_q];
   assign min_bcd    = to_bcd(head_entry[11:6]);
   assign sec_bcd    = to_bcd(head_entry[5:0]);

   // Display registers follow the head entry one edge behind; blank when empty.
   always_ff @(posedge incClk or posedge rst) begin
      if (rst) begin
         min_tens_q <= '0;
         min_ones_q <= '0;
         sec_tens_q <= '0;
         sec_ones_q <= '0;
         valid_q    <= 1'b0;
      end else if (empty_w) begin
         min_tens_q <= '0;
         min_ones_q <= '0;
         sec_tens_q <= '0;
         sec_ones_q <= '0;
         valid_q    <= 1'b0;
      end else begin
         min_tens_q <= min_bcd[6:4];
         min_ones_q <= min_bcd[3:0];
         sec_tens_q <= sec_bcd[6:4];
         sec_ones_q <= sec_bcd[3:0];
         valid_q    <= 1'b1;
      end
   end

   assign lap_min_tens = min_tens_q;
   assign lap_min_ones = min_ones_q;
   assign lap_sec_tens = sec_tens_q;
   assign lap_sec_ones = sec_ones_q;
   assign lap_valid    = valid_q;
   assign count        = count_q;
   assign full         = full_w;
   assign empty        = empty_w;
   assign overflow     = ovf_q;

endmodule
